toll_lane_ctrl: RTL and testbench
=================================

// Module: toll_lane_ctrl
// PURPOSE
//  Lane sequencer for the toll gate. Drives en[1:0] into the input synchroniser (01 = car phase, 10 = hi-pass phase).
//  Consumes the synchroniser's car_sync and hipass_sync outputs, computes the fee and opens the gate.
//  Flags evasion on card timeout and on blacklisted card 4'b1111.
// PARAMETERS
//  BASE_FEE     20  8-bit class-0 full fee
//  TIMEOUT      16  cycles to wait in HIPASS for a card read, >=1
//  GATE_CYCLES   8  cycles gate_open is held, >=1
//  VIOL_CYCLES   4  cycles violation is held, >=1
// PORTS
//  clk           in   1  clock, rising edge
//  rst           in   1  asynchronous, active-low reset
//  car_sync      in   1  car-detected pulse from the synchroniser
//  hipass_sync   in   4  card code; 0 = no read; [3:2] class, [1:0] discount
//  force_open    in   1  operator override, level
//  en            out  2  synchroniser phase select
//  gate_open     out  1  gate actuator
//  fee           out  8  fee of the current transaction
//  charge_valid  out  1  one-cycle pulse: fee valid
//  violation     out  1  evasion / blacklist alarm
//  busy          out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async, also mid-transaction):
//   - state=IDLE; en=01; all counters 0.
//   - gate_open, fee, charge_valid, violation, busy = 0.
//  Outputs are registered or decoded from the registered state only; no input->output combinational path.
//  States and en per state: IDLE=01, HIPASS=10, CHARGE=00, GATE=00, VIOL=00.
//  IDLE:
//   - car_sync=1 -> HIPASS next cycle; timeout counter loaded with TIMEOUT.
//  HIPASS:
//   - hipass_sync!=0 and !=4'b1111 -> CHARGE; the code is latched.
//   - hipass_sync==4'b1111 -> VIOL.
//   - Otherwise the counter decrements each cycle; at counter==1 with no read -> VIOL.
//   - A read on the same cycle the counter expires wins: go to CHARGE.
//  CHARGE (exactly 1 cycle):
//   - charge_valid=1; fee holds its value until the next CHARGE or reset.
//   - c=code[3:2], d=code[1:0].
//   - raw = BASE_FEE*(c+1), computed 10-bit, saturated to 255.
//   - d=00 -> fee=raw; d=01 -> raw>>1; d=10 -> 0 (exempt); d=11 -> raw>>2.
//   - Next state: GATE with counter=GATE_CYCLES.
//  GATE:
//   - gate_open=1; counter decrements; at 1 -> IDLE.
//   - car_sync is ignored (en=00).
//  VIOL:
//   - violation=1, gate_open=0 for VIOL_CYCLES, then IDLE.
//  force_open=1 has priority over every other transition:
//   - from any state -> GATE with counter reloaded; no charge_valid; violation cleared.
//   - The counter is held at GATE_CYCLES while force_open stays high.
//   - After release: GATE_CYCLES more cycles, then IDLE.
//  Latency: car_sync at edge N -> en=10 from N+1; card read at edge M -> charge_valid at M+1, gate_open from M+2.
// CONFIGURATION
//  TOLL_LANE_STATS_EN:
//   - Adds outputs veh_count[7:0] and revenue[15:0], reset 0.
//   - veh_count increments on every entry to CHARGE; wraps 255->0.
//   - revenue += fee on every charge_valid; saturates at 16'hFFFF.
//   - Forced openings are not counted.
//  Undefined: the ports and logic are absent; behaviour is otherwise identical.
// TESTING
//  1. car_sync pulse, then hipass_sync=4'b0100 after 3 cycles:
//     -> en 01->10; charge_valid 1 cycle with fee=40; gate_open 8 cycles; back to IDLE with en=01.
//  2. hipass_sync=4'b1001 -> fee=30; 4'b1110 -> fee=0, gate still opens; 4'b1011 -> fee=15.
//  3. car_sync with no card for 16 cycles:
//     -> violation=1 for 4 cycles, gate_open stays 0, no charge_valid, then IDLE.
//  4. hipass_sync=4'b1111 in HIPASS -> VIOL next cycle; fee unchanged.
//  5. BASE_FEE=100 with class 3, d=00 -> fee=255 (saturated).
//     force_open mid-HIPASS -> gate_open next cycle, held until 8 cycles after release.
//  6. rst low during GATE (cycle 3) -> all outputs 0 immediately, en=01 on release.
//     With TOLL_LANE_STATS_EN, 3 charges of 40 -> veh_count=3, revenue=120.

Source files
------------

// File: rtl/toll_lane_ctrl.sv
// Toll-lane sequencer: car detect -> hi-pass card read -> charge -> gate, with evasion/blacklist alarm.
// Optional vehicle/revenue statistics are built when TOLL_LANE_STATS_EN is defined.
module toll_lane_ctrl #(
   parameter int BASE_FEE    = 20,
   parameter int TIMEOUT     = 16,
   parameter int GATE_CYCLES = 8,
   parameter int VIOL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        car_sync,
   input  logic [3:0]  hipass_sync,
   input  logic        force_open,
   output logic [1:0]  en,
   output logic        gate_open,
   output logic [7:0]  fee,
   output logic        charge_valid,
   output logic        violation,
   output logic        busy
`ifdef TOLL_LANE_STATS_EN
   ,
   output logic [7:0]  veh_count,
   output logic [15:0] revenue
`endif
);

   localparam int MAX_TG = (TIMEOUT > GATE_CYCLES) ? TIMEOUT : GATE_CYCLES;
   localparam int MAX_C  = (MAX_TG > VIOL_CYCLES) ? MAX_TG : VIOL_CYCLES;
   localparam int CNT_W  = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] GATE_LD = CNT_W'(GATE_CYCLES);
   localparam logic [CNT_W-1:0] VIOL_LD = CNT_W'(VIOL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [9:0]       BASE10  = 10'(BASE_FEE);

   localparam logic [1:0] EN_CAR    = 2'b01;
   localparam logic [1:0] EN_HIPASS = 2'b10;
   localparam logic [1:0] EN_OFF    = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HIPASS = 3'd1,
      ST_CHARGE = 3'd2,
      ST_GATE   = 3'd3,
      ST_VIOL   = 3'd4
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       en_r;
   logic             gate_r;
   logic [7:0]       fee_r;
   logic             charge_valid_r;
   logic             viol_r;
   logic             busy_r;

   // Fee is evaluated from the card code at the read edge so it is valid together with charge_valid
   function automatic logic [7:0] calc_fee(input logic [3:0] code);
      logic [9:0] raw;
      logic [7:0] sat;
      raw = (BASE10 * {8'd0, code[3:2]}) + BASE10;
      sat = (raw > 10'd255) ? 8'hFF : raw[7:0];
      case (code[1:0])
         2'b00:   calc_fee = sat;
         2'b01:   calc_fee = {1'b0, sat[7:1]};
         2'b10:   calc_fee = 8'd0;
         2'b11:   calc_fee = {2'b00, sat[7:2]};
         default: calc_fee = sat;
      endcase
   endfunction

   // Lane FSM: state, shared cycle counter and every registered output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         cnt_r          <= '0;
         en_r           <= EN_CAR;
         gate_r         <= 1'b0;
         fee_r          <= 8'd0;
         charge_valid_r <= 1'b0;
         viol_r         <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         charge_valid_r <= 1'b0;
         if (force_open) begin
            state_r <= ST_GATE;
            cnt_r   <= GATE_LD;
            en_r    <= EN_OFF;
            gate_r  <= 1'b1;
            viol_r  <= 1'b0;
            busy_r  <= 1'b1;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (car_sync) begin
                     state_r <= ST_HIPASS;
                     cnt_r   <= TO_LD;
                     en_r    <= EN_HIPASS;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_HIPASS: begin
                  // A valid read beats an expiring counter; the blacklist code beats both
                  if (hipass_sync == 4'b1111) begin
                     state_r <= ST_VIOL;
                     cnt_r   <= VIOL_LD;
                     en_r    <= EN_OFF;
                     viol_r  <= 1'b1;
                  end else if (hipass_sync != 4'b0000) begin
                     state_r        <= ST_CHARGE;
                     en_r           <= EN_OFF;
                     fee_r          <= calc_fee(hipass_sync);
                     charge_valid_r <= 1'b1;
                  end else if (cnt_r == CNT_ONE) begin
                     state_r <= ST_VIOL;
                     cnt_r   <= VIOL_LD;
                     en_r    <= EN_OFF;
                     viol_r  <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r - CNT_ONE;
                  end
               end
               ST_CHARGE: begin
                  state_r <= ST_GATE;
                  cnt_r   <= GATE_LD;
                  gate_r  <= 1'b1;
               end
               ST_GATE: begin
                  if (cnt_r == CNT_ONE) begin
                     state_r <= ST_IDLE;
                     cnt_r   <= '0;
                     en_r    <= EN_CAR;
                     gate_r  <= 1'b0;
                     busy_r  <= 1'b0;
                  end else begin
                     cnt_r <= cnt_r - CNT_ONE;
                  end
               end
               ST_VIOL: begin
                  if (cnt_r == CNT_ONE) begin
                     state_r <= ST_IDLE;
                     cnt_r   <= '0;
                     en_r    <= EN_CAR;
                     viol_r  <= 1'b0;
                     busy_r  <= 1'b0;
                  end else begin
                     cnt_r <= cnt_r - CNT_ONE;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  cnt_r   <= '0;
                  en_r    <= EN_CAR;
                  gate_r  <= 1'b0;
                  viol_r  <= 1'b0;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign en           = en_r;
   assign gate_open    = gate_r;
   assign fee          = fee_r;
   assign charge_valid = charge_valid_r;
   assign violation    = viol_r;
   assign busy         = busy_r;

`ifdef TOLL_LANE_STATS_EN
   logic [7:0]  veh_count_r;
   logic [15:0] revenue_r;
   logic [16:0] rev_sum_s;

   assign rev_sum_s = {1'b0, revenue_r} + {9'd0, fee_r};

   // Statistics advance only on a charge pulse, so forced openings never count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         veh_count_r <= 8'd0;
         revenue_r   <= 16'd0;
      end else if (charge_valid_r) begin
         veh_count_r <= veh_count_r + 8'd1;
         revenue_r   <= rev_sum_s[16] ? 16'hFFFF : rev_sum_s[15:0];
      end else begin
         veh_count_r <= veh_count_r;
         revenue_r   <= revenue_r;
      end
   end

   assign veh_count = veh_count_r;
   assign revenue   = revenue_r;
`endif

endmodule

// File: tb/tb_toll_lane_ctrl.sv
// Bench for toll_lane_ctrl: directed scenarios plus random traffic against a countdown-based lane model.
// A second instance with BASE_FEE=100 exercises fee saturation.
module tb_toll_lane_ctrl;

   localparam int TIMEOUT     = 16;
   localparam int GATE_CYCLES = 8;
   localparam int VIOL_CYCLES = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       car_sync = 1'b0;
   logic [3:0] hipass_sync = 4'd0;
   logic       force_open = 1'b0;

   logic [1:0] en, en_b;
   logic       gate_open, charge_valid, violation, busy;
   logic       gate_open_b, charge_valid_b, violation_b, busy_b;
   logic [7:0] fee, fee_b;
`ifdef TOLL_LANE_STATS_EN
   logic [7:0]  veh_count, veh_count_b;
   logic [15:0] revenue, revenue_b;
`endif

   toll_lane_ctrl dut (
      .clk(clk), .rst(rst), .car_sync(car_sync), .hipass_sync(hipass_sync),
      .force_open(force_open), .en(en), .gate_open(gate_open), .fee(fee),
      .charge_valid(charge_valid), .violation(violation), .busy(busy)
`ifdef TOLL_LANE_STATS_EN
      , .veh_count(veh_count), .revenue(revenue)
`endif
   );

   toll_lane_ctrl #(.BASE_FEE(100)) dut_b (
      .clk(clk), .rst(rst), .car_sync(car_sync), .hipass_sync(hipass_sync),
      .force_open(force_open), .en(en_b), .gate_open(gate_open_b), .fee(fee_b),
      .charge_valid(charge_valid_b), .violation(violation_b), .busy(busy_b)
`ifdef TOLL_LANE_STATS_EN
      , .veh_count(veh_count_b), .revenue(revenue_b)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: remaining-cycle counts for each lane activity
   int hip_left, gate_left, viol_left;
   bit m_cv;
   int m_fee, m_fee_b, m_veh, m_rev;

   function automatic int fee_of(input int base, input logic [3:0] code);
      int c = int'(code[3:2]);
      int d = int'(code[1:0]);
      int raw = base * (c + 1);
      if (raw > 255) raw = 255;
      case (d)
         0: return raw;
         1: return raw / 2;
         2: return 0;
         default: return raw / 4;
      endcase
   endfunction

   task automatic model_reset();
      hip_left = 0; gate_left = 0; viol_left = 0; m_cv = 1'b0;
      m_fee = 0; m_fee_b = 0; m_veh = 0; m_rev = 0;
   endtask

   task automatic model_edge(input logic c, input logic [3:0] h, input logic f);
      bit was_cv = m_cv;
      m_cv = 1'b0;
      if (was_cv) begin
         m_veh = (m_veh + 1) % 256;
         m_rev = (m_rev + m_fee > 65535) ? 65535 : m_rev + m_fee;
      end
      if (f) begin
         gate_left = GATE_CYCLES; hip_left = 0; viol_left = 0;
      end else if (was_cv) begin
         gate_left = GATE_CYCLES;
      end else if (gate_left > 0) begin
         gate_left--;
      end else if (viol_left > 0) begin
         viol_left--;
      end else if (hip_left > 0) begin
         if (h == 4'hF) begin
            hip_left = 0; viol_left = VIOL_CYCLES;
         end else if (h != 4'h0) begin
            hip_left = 0; m_cv = 1'b1;
            m_fee = fee_of(20, h); m_fee_b = fee_of(100, h);
         end else begin
            hip_left--;
            if (hip_left == 0) viol_left = VIOL_CYCLES;
         end
      end else if (c) begin
         hip_left = TIMEOUT;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      bit active = m_cv || gate_left > 0 || viol_left > 0 || hip_left > 0;
      int exp_en = (m_cv || gate_left > 0 || viol_left > 0) ? 0 : (hip_left > 0 ? 2 : 1);
      chk("en", int'(en), exp_en);
      chk("gate_open", int'(gate_open), int'(gate_left > 0));
      chk("fee", int'(fee), m_fee);
      chk("charge_valid", int'(charge_valid), int'(m_cv));
      chk("violation", int'(violation), int'(viol_left > 0));
      chk("busy", int'(busy), int'(active));
      chk("fee_b", int'(fee_b), m_fee_b);
      chk("charge_valid_b", int'(charge_valid_b), int'(m_cv));
`ifdef TOLL_LANE_STATS_EN
      chk("veh_count", int'(veh_count), m_veh);
      chk("revenue", int'(revenue), m_rev);
`endif
   endtask

   task automatic step(input logic c, input logic [3:0] h, input logic f);
      car_sync = c; hipass_sync = h; force_open = f;
      @(posedge clk);
      model_edge(c, h, f);
      @(negedge clk);
      compare_all();
   endtask

   task automatic txn(input logic [3:0] code, input int exp_fee);
      step(1'b1, 4'h0, 1'b0);
      step(1'b0, code, 1'b0);
      chk("txn_fee_lit", int'(fee), exp_fee);
      chk("txn_cv_lit", int'(charge_valid), 1);
      repeat (10) step(1'b0, 4'h0, 1'b0);
   endtask

   initial begin
      int n;
      model_reset();
      #1 rst = 1'b0;
      @(negedge clk);
      compare_all();
      chk("reset_en_lit", int'(en), 1);
      rst = 1'b1;

      // Basic transaction with gate-hold count
      step(1'b1, 4'h0, 1'b0);
      chk("hipass_en_lit", int'(en), 2);
      step(1'b0, 4'h0, 1'b0);
      step(1'b0, 4'h0, 1'b0);
      step(1'b0, 4'b0100, 1'b0);
      chk("fee40_lit", int'(fee), 40);
      chk("cv_lit", int'(charge_valid), 1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 4'h0, 1'b0);
         if (gate_open) n++;
         else if (n > 0) break;
      end
      chk("gate_len_lit", n, GATE_CYCLES);
      chk("idle_en_lit", int'(en), 1);

      // Discounts
      txn(4'b1001, 30);
      txn(4'b1110, 0);
      txn(4'b1011, 15);

      // Card timeout
      step(1'b1, 4'h0, 1'b0);
      repeat (15) step(1'b0, 4'h0, 1'b0);
      chk("pre_timeout_lit", int'(violation), 0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 4'h0, 1'b0);
         if (violation) n++;
         else if (n > 0) break;
      end
      chk("viol_len_lit", n, VIOL_CYCLES);

      // Blacklist
      step(1'b1, 4'h0, 1'b0);
      step(1'b0, 4'hF, 1'b0);
      chk("blacklist_lit", int'(violation), 1);
      chk("blacklist_fee_lit", int'(fee), 15);
      repeat (5) step(1'b0, 4'h0, 1'b0);

      // Saturation on the BASE_FEE=100 instance
      step(1'b1, 4'h0, 1'b0);
      step(1'b0, 4'b1100, 1'b0);
      chk("sat_fee_lit", int'(fee_b), 255);
      chk("class3_fee_lit", int'(fee), 80);
      repeat (10) step(1'b0, 4'h0, 1'b0);

      // Force open in HIPASS
      step(1'b1, 4'h0, 1'b0);
      step(1'b0, 4'h0, 1'b0);
      step(1'b0, 4'h0, 1'b1);
      chk("force_gate_lit", int'(gate_open), 1);
      step(1'b0, 4'h0, 1'b1);
      step(1'b0, 4'h0, 1'b1);
      repeat (10) step(1'b0, 4'h0, 1'b0);

      // Asynchronous reset in the third gate cycle
      step(1'b1, 4'h0, 1'b0);
      step(1'b0, 4'b0100, 1'b0);
      repeat (3) step(1'b0, 4'h0, 1'b0);
      rst = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("rst_gate_lit", int'(gate_open), 0);
      @(negedge clk);
      rst = 1'b1;

      // Three charges of 40
      txn(4'b0100, 40);
      txn(4'b0100, 40);
      txn(4'b0100, 40);
`ifdef TOLL_LANE_STATS_EN
      chk("veh3_lit", int'(veh_count), 3);
      chk("rev120_lit", int'(revenue), 120);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic       c;
         logic [3:0] h;
         logic       f;
         c = ($urandom_range(0, 3) == 0);
         h = ($urandom_range(0, 9) < 7) ? 4'h0 : 4'($urandom_range(1, 15));
         f = ($urandom_range(0, 39) == 0);
         step(c, h, f);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
